mem_access: RTL and testbench

Memory-access stage of the five-stage MIPS pipeline. Sits directly downstream of the EX/MEM pipeline register. Consumes its write-back triple plus the memory op and store data, and runs a request/acknowledge data-bus transaction for loads and stores. It stalls the pipeline while a transaction is outstanding, then hands the (load-extended) write-back triple to the MEM/WB register.

---
 rtl/mem_access.sv | 90 +++++++++
 tb/tb_mem_access.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/mem_access.sv
// mem_access: MIPS MEM stage; runs req/ack bus transactions for loads/stores and stalls the pipeline meanwhile.
// Optional MEM_ACCESS_ALIGN_CHECK_EN rejects misaligned halfword/word accesses with an addr_err pulse.
module mem_access (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_wreg_write,
  input  logic [4:0]  mem_wreg_addr,
  input  logic [31:0] mem_wreg_data,
  input  logic [3:0]  mem_op,
  input  logic [31:0] mem_store_data,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata,
  output logic        stall_req,
  output logic        addr_err,
  output logic        wb_wreg_write,
  output logic [4:0]  wb_wreg_addr,
  output logic [31:0] wb_wreg_data
);
  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
  state_t state, state_nx;
  logic [3:0] op_q;
  logic [31:0] addr_q, sdata_q, rdata_q;
  logic [4:0] waddr_q;
  logic wwr_q;
  logic is_mem, mis, start, q_byte, q_half, q_word, q_ld, q_st;
  logic [7:0] ld_b;
  logic [15:0] ld_h;
  logic [31:0] ld_val;
  assign is_mem = mem_op >= 4'd1 && mem_op <= 4'd8;
`ifdef MEM_ACCESS_ALIGN_CHECK_EN
  assign mis = ((mem_op == 4'd3 || mem_op == 4'd4 || mem_op == 4'd7) && mem_wreg_data[0]) ||
               ((mem_op == 4'd5 || mem_op == 4'd8) && |mem_wreg_data[1:0]);
`else
  assign mis = 1'b0;
`endif
  assign start = state == IDLE && is_mem && !mis;
  assign q_byte = op_q == 4'd1 || op_q == 4'd2 || op_q == 4'd6;
  assign q_half = op_q == 4'd3 || op_q == 4'd4 || op_q == 4'd7;
  assign q_word = op_q == 4'd5 || op_q == 4'd8;
  assign q_ld = op_q >= 4'd1 && op_q <= 4'd5;
  assign q_st = op_q >= 4'd6 && op_q <= 4'd8;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      op_q <= '0;
      addr_q <= '0;
      sdata_q <= '0;
      rdata_q <= '0;
      waddr_q <= '0;
      wwr_q <= 1'b0;
    end else begin
      state <= state_nx;
      if (start) begin
        op_q <= mem_op;
        addr_q <= mem_wreg_data;
        sdata_q <= mem_store_data;
        waddr_q <= mem_wreg_addr;
        wwr_q <= mem_wreg_write;
      end
      if (state == ACCESS && bus_ack && q_ld) rdata_q <= bus_rdata;
    end
  end
  always_comb
    state_nx = state == IDLE   ? (start ? ACCESS : IDLE) :
               state == ACCESS ? (bus_ack ? DONE : ACCESS) : IDLE;
  // Bus side is a pure function of the latches, so it cannot move while the pipeline input changes.
  assign bus_addr = {addr_q[31:2], 2'b00};
  assign bus_be = q_byte ? 4'b0001 << addr_q[1:0] : q_half ? (addr_q[1] ? 4'b1100 : 4'b0011) :
                  q_word ? 4'b1111 : 4'b0000;
  assign bus_wdata = op_q == 4'd6 ? {4{sdata_q[7:0]}} : op_q == 4'd7 ? {2{sdata_q[15:0]}} :
                     op_q == 4'd8 ? sdata_q : 32'd0;
  assign ld_b = rdata_q[{addr_q[1:0], 3'b000} +: 8];
  assign ld_h = addr_q[1] ? rdata_q[31:16] : rdata_q[15:0];
  assign ld_val = op_q == 4'd1 ? {{24{ld_b[7]}}, ld_b} : op_q == 4'd2 ? {24'd0, ld_b} :
                  op_q == 4'd3 ? {{16{ld_h[15]}}, ld_h} : op_q == 4'd4 ? {16'd0, ld_h} : rdata_q;
  always_comb begin
    bus_req = state == ACCESS;
    bus_we = bus_req && q_st;
    stall_req = start || bus_req;
    addr_err = state == IDLE && is_mem && mis;
    wb_wreg_write = state == IDLE ? mem_wreg_write && !is_mem : state == DONE && wwr_q && q_ld;
    wb_wreg_addr = state == IDLE ? mem_wreg_addr : waddr_q;
    wb_wreg_data = state == IDLE ? mem_wreg_data : (state == DONE && q_ld) ? ld_val : 32'd0;
  end
endmodule

// File: tb/tb_mem_access.sv
// tb_mem_access: directed vectors against a transaction-level model of the MEM stage, checked every cycle.
module tb_mem_access;
  logic clk = 1'b0, rst = 1'b0;
  logic mem_wreg_write = 1'b0, bus_ack = 1'b0;
  logic [4:0] mem_wreg_addr = '0;
  logic [31:0] mem_wreg_data = '0, mem_store_data = '0, bus_rdata = '0;
  logic [3:0] mem_op = '0;
  logic bus_req, bus_we, stall_req, addr_err, wb_wreg_write;
  logic [31:0] bus_addr, bus_wdata, wb_wreg_data;
  logic [3:0] bus_be;
  logic [4:0] wb_wreg_addr;
  always #5 clk = ~clk;
  mem_access dut (
    .clk(clk), .rst(rst), .mem_wreg_write(mem_wreg_write), .mem_wreg_addr(mem_wreg_addr),
    .mem_wreg_data(mem_wreg_data), .mem_op(mem_op), .mem_store_data(mem_store_data),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_be(bus_be), .bus_wdata(bus_wdata),
    .bus_ack(bus_ack), .bus_rdata(bus_rdata), .stall_req(stall_req), .addr_err(addr_err),
    .wb_wreg_write(wb_wreg_write), .wb_wreg_addr(wb_wreg_addr), .wb_wreg_data(wb_wreg_data)
  );
  int n_vec = 0, n_err = 0, stall_cnt = 0;
  logic chk = 1'b0;
  logic e_req, e_we, e_stall, e_err, e_wbw, c_bus, c_wba, c_wbd;
  logic [31:0] e_addr, e_wdata, e_wbd, obs_addr, obs_wdata;
  logic [3:0] e_be, obs_be;
  logic [4:0] e_wba;
  function automatic int m_sz(input logic [3:0] op);
    return (op == 1 || op == 2 || op == 6) ? 1 : (op == 3 || op == 4 || op == 7) ? 2 :
           (op == 5 || op == 8) ? 4 : 0;
  endfunction
  function automatic logic [3:0] m_be(input logic [3:0] op, input logic [31:0] a);
    int sz = m_sz(op);
    int off = (int'(a % 4) / sz) * sz;
    return 4'(((1 << sz) - 1) << off);
  endfunction
  function automatic logic [31:0] m_wdata(input logic [3:0] op, input logic [31:0] d);
    int sz = m_sz(op);
    return sz == 1 ? (d & 32'hFF) * 32'h0101_0101 : sz == 2 ? (d & 32'hFFFF) * 32'h0001_0001 : d;
  endfunction
  function automatic logic [31:0] m_load(input logic [3:0] op, input logic [31:0] a, input logic [31:0] rd);
    int sz = m_sz(op);
    int off = (int'(a % 4) / sz) * sz;
    logic [31:0] v;
    if (sz == 4) return rd;
    v = (rd >> (8 * off)) & ((32'd1 << (8 * sz)) - 1);
    if ((op == 1 || op == 3) && v >= (32'd1 << (8 * sz - 1))) v = v - (32'd1 << (8 * sz));
    return v;
  endfunction
  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask
  always @(negedge clk) if (chk) begin
    cmp("bus_req", bus_req, e_req);
    cmp("stall_req", stall_req, e_stall);
    cmp("addr_err", addr_err, e_err);
    cmp("wb_wreg_write", wb_wreg_write, e_wbw);
    if (c_bus) begin
      cmp("bus_we", bus_we, e_we);
      cmp("bus_addr", bus_addr, e_addr);
      cmp("bus_be", bus_be, e_be);
      if (e_we) cmp("bus_wdata", bus_wdata, e_wdata);
    end
    if (c_wba) cmp("wb_wreg_addr", wb_wreg_addr, e_wba);
    if (c_wbd) cmp("wb_wreg_data", wb_wreg_data, e_wbd);
    if (stall_req) stall_cnt++;
  end
  task automatic set_nop_exp(input logic ww, input logic [4:0] wa, input logic [31:0] d);
    e_req = 0; e_err = 0; c_bus = 0; e_stall = 0; e_wbw = ww; c_wba = 1; c_wbd = 1; e_wba = wa; e_wbd = d;
  endtask
  // One pipeline op: IDLE cycle, waits+1 ACCESS cycles (ack on the last), then DONE; returns in DONE.
  task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] sd,
                        input logic [4:0] wa, input logic ww, input logic [31:0] rd, input int waits);
    logic ld = op >= 1 && op <= 5, st = op >= 6 && op <= 8;
    @(posedge clk); #1;
    mem_op = op; mem_wreg_data = a; mem_store_data = sd; mem_wreg_addr = wa; mem_wreg_write = ww; bus_ack = 0;
    set_nop_exp(ww, wa, a);
    if (ld || st) begin e_stall = 1; e_wbw = 0; c_wba = 0; c_wbd = 0; end
    chk = 1;
    if (!(ld || st)) return;
    for (int k = 0; k <= waits; k++) begin
      @(posedge clk); #1;
      mem_op = (op == 8) ? 4'd5 : 4'd8; mem_wreg_data = ~a; mem_store_data = ~sd;
      mem_wreg_addr = ~wa; mem_wreg_write = ~ww;
      bus_ack = (k == waits); bus_rdata = (k == waits) ? rd : 32'hDEAD_BEEF;
      e_req = 1; e_stall = 1; e_wbw = 0; c_wba = 0; c_wbd = 0; c_bus = 1;
      e_we = st; e_addr = a & ~32'd3; e_be = m_be(op, a); e_wdata = m_wdata(op, sd);
      if (k == 0) begin #1; obs_addr = bus_addr; obs_be = bus_be; obs_wdata = bus_wdata; end
    end
    @(posedge clk); #1;
    bus_ack = 0; bus_rdata = ~rd;
    e_req = 0; e_stall = 0; c_bus = 0; e_wbw = ld && ww; c_wba = 1; c_wbd = ld;
    e_wba = wa; e_wbd = m_load(op, a, rd);
  endtask
  int s0;
  initial begin
    #3;
    cmp("rst bus_req", bus_req, 0); cmp("rst bus_we", bus_we, 0); cmp("rst bus_addr", bus_addr, 0);
    cmp("rst bus_be", bus_be, 0); cmp("rst bus_wdata", bus_wdata, 0); cmp("rst stall_req", stall_req, 0);
    cmp("rst addr_err", addr_err, 0); cmp("rst wb_write", wb_wreg_write, 0); cmp("rst wb_data", wb_wreg_data, 0);
    @(negedge clk); rst = 1;
    run_op(0, 32'h1234, 0, 5, 1, 0, 0);
    #1 cmp("nop wb_write", wb_wreg_write, 1); cmp("nop wb_addr", wb_wreg_addr, 5);
    cmp("nop wb_data", wb_wreg_data, 32'h1234);
    s0 = stall_cnt;
    run_op(1, 32'h103, 0, 7, 1, 32'h80FF_FF7F, 0);
    #1 cmp("lb data", wb_wreg_data, 32'hFFFF_FF80); cmp("lb addr", obs_addr, 32'h100);
    cmp("lb be", obs_be, 4'b1000); cmp("lb stall cycles", stall_cnt - s0, 2);
    s0 = stall_cnt;
    run_op(7, 32'h202, 32'hAAAA_BEEF, 9, 1, 32'h1357_9BDF, 3);
    #1 cmp("sh be", obs_be, 4'b1100); cmp("sh wdata", obs_wdata, 32'hBEEF_BEEF);
    cmp("sh stall cycles", stall_cnt - s0, 5); cmp("sh wb_write", wb_wreg_write, 0);
`ifdef MEM_ACCESS_ALIGN_CHECK_EN
    @(posedge clk); #1;
    mem_op = 5; mem_wreg_data = 32'h301; mem_wreg_addr = 2; mem_wreg_write = 1;
    set_nop_exp(0, 2, 32'h301); e_err = 1; c_wba = 0; c_wbd = 0;
    run_op(0, 32'h77, 0, 3, 1, 0, 0);
`else
    run_op(5, 32'h301, 0, 2, 1, 32'h1122_3344, 0);
    #1 cmp("lw unaligned addr", obs_addr, 32'h300); cmp("lw unaligned be", obs_be, 4'b1111);
    cmp("lw unaligned data", wb_wreg_data, 32'h1122_3344);
`endif
    run_op(4, 32'h402, 0, 3, 1, 32'h8001_0000, 0);
    #1 cmp("lhu data", wb_wreg_data, 32'h0000_8001);
    run_op(5, 32'h404, 0, 4, 1, 32'hCAFE_F00D, 2);
    #1 cmp("lw data", wb_wreg_data, 32'hCAFE_F00D);
    run_op(3, 32'hA2, 0, 11, 1, 32'h9ABC_1234, 1);
    #1 cmp("lh data", wb_wreg_data, 32'hFFFF_9ABC);
    run_op(6, 32'h11, 32'h0000_00C3, 12, 0, 0, 0);
    #1 cmp("sb be", obs_be, 4'b0010); cmp("sb wdata", obs_wdata, 32'hC3C3_C3C3);
    run_op(8, 32'h24, 32'h0BAD_CAFE, 13, 1, 0, 1);
    #1 cmp("sw wdata", obs_wdata, 32'h0BAD_CAFE);
    run_op(2, 32'h1, 0, 14, 0, 32'h0000_F500, 0);
    // Reset dropped mid-transaction must kill the request without a clock edge.
    @(posedge clk); #1;
    mem_op = 5; mem_wreg_data = 32'h500; mem_wreg_addr = 8; mem_wreg_write = 1; bus_ack = 0;
    set_nop_exp(0, 8, 32'h500); e_stall = 1; c_wba = 0; c_wbd = 0;
    @(posedge clk); #1 chk = 0; mem_op = 0; mem_wreg_data = 32'h66; mem_wreg_addr = 6;
    #1 cmp("access before rst", bus_req, 1);
    rst = 0;
    #1 cmp("async rst bus_req", bus_req, 0); cmp("async rst stall", stall_req, 0);
    @(posedge clk); #2 rst = 1; bus_ack = 1;
    set_nop_exp(1, 6, 32'h66); chk = 1;
    repeat (3) @(posedge clk);
    #1 bus_ack = 0;
    run_op(2, 32'h2, 0, 15, 1, 32'h00AB_0000, 0);
    #1 cmp("lbu data", wb_wreg_data, 32'h0000_00AB);
    run_op(0, 32'h0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    chk = 0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
